// File: rtl/mig_netlist_eval_if.sv
// mig_netlist_eval_if
//   Descriptor stream and result handshake bundle for mig_netlist_eval.
//   Optional macro MIG_EVAL_ONESCNT_EN adds out_ones (popcount of out_tt).
// Signals
//   in_valid  / in_ready   descriptor beat handshake
//   in_last               beat carries the output selector and ends the netlist
//   in_gate               {c2,s2,c1,s1,c0,s0}
//   out_valid / out_ready  result handshake
//   out_tt, out_err        result truth table and malformed-netlist flag
//   out_ones              popcount of out_tt (MIG_EVAL_ONESCNT_EN only)
// Modports: master = netlist source / result sink, slave = evaluator.
interface mig_netlist_eval_if #(
  parameter int SEL_W = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic                     in_last;
  logic [3*(SEL_W+1)-1:0]   in_gate;
  logic                     out_valid;
  logic                     out_ready;
  logic [15:0]              out_tt;
  logic                     out_err;
`ifdef MIG_EVAL_ONESCNT_EN
  logic [4:0]               out_ones;

  modport master (
    output in_valid, in_last, in_gate, out_ready,
    input  in_ready, out_valid, out_tt, out_err, out_ones
  );
  modport slave (
    input  in_valid, in_last, in_gate, out_ready,
    output in_ready, out_valid, out_tt, out_err, out_ones
  );
`else
  modport master (
    output in_valid, in_last, in_gate, out_ready,
    input  in_ready, out_valid, out_tt, out_err
  );
  modport slave (
    input  in_valid, in_last, in_gate, out_ready,
    output in_ready, out_valid, out_tt, out_err
  );
`endif
endinterface

// File: rtl/mig_netlist_eval.sv
// mig_netlist_eval
//   Sequential evaluator for 4-input majority-inverter-graph netlists.
//   Gate descriptors are streamed in, then evaluated one gate per cycle on
//   16-bit bit-parallel truth tables; the selected (optionally complemented)
//   signal is returned as the output truth table.
//   Optional macro MIG_EVAL_ONESCNT_EN adds bus.out_ones = popcount(out_tt).
// Ports
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   mig_netlist_eval_if.slave (descriptor stream in, result out)
// States
//   LOAD | accepting descriptors, in_ready=1
//   EVAL | gate k evaluated in cycle k; last cycle also forms the output
//   OUT  | result held until out_ready
module mig_netlist_eval #(
  parameter int MAX_GATES = 8,
  parameter int SEL_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  mig_netlist_eval_if.slave bus
);

  localparam int GW    = SEL_W + 1;
  localparam int DW    = 3 * GW;
  localparam int CNT_W = $clog2(MAX_GATES + 1);
  localparam int IDX_W = (MAX_GATES > 1) ? $clog2(MAX_GATES) : 1;
  localparam int NSIG  = 2 ** SEL_W;

  typedef enum logic [1:0] {LOAD, EVAL, OUT} state_t;

  state_t             state;
  logic [CNT_W-1:0]   n_gates;
  logic [CNT_W-1:0]   k;
  logic               err;
  logic [SEL_W-1:0]   out_sel;
  logic               out_cpl;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [15:0]        out_tt_q;
  logic               out_err_q;

  logic [DW-1:0]      desc    [MAX_GATES];
  logic [15:0]        gate_tt [MAX_GATES];
  logic [15:0]        sig_tab [NSIG];

  // signal space: constants, primary inputs, then already evaluated gates
  always_comb begin
    for (int i = 0; i < NSIG; i++) sig_tab[i] = 16'h0000;
    sig_tab[1] = 16'hAAAA;
    sig_tab[2] = 16'hCCCC;
    sig_tab[3] = 16'hF0F0;
    sig_tab[4] = 16'hFF00;
    for (int g = 0; g < MAX_GATES; g++) begin
      if (5 + g < NSIG) sig_tab[5+g] = gate_tt[g];
    end
  end

  logic [DW-1:0]    cur;
  logic [SEL_W-1:0] s0, s1, s2;
  logic             c0, c1, c2;
  logic [15:0]      fa, fb, fc, gate_val;
  logic             gate_fwd;
  logic             has_gates;
  logic             last_step;
  logic             out_bad;
  logic             err_final;
  logic [15:0]      out_src;
  logic [15:0]      tt_final;

  assign cur = desc[k[IDX_W-1:0]];
  assign s0  = cur[SEL_W-1:0];
  assign c0  = cur[SEL_W];
  assign s1  = cur[GW+SEL_W-1:GW];
  assign c1  = cur[GW+SEL_W];
  assign s2  = cur[2*GW+SEL_W-1:2*GW];
  assign c2  = cur[2*GW+SEL_W];

  assign fa       = sig_tab[s0] ^ {16{c0}};
  assign fb       = sig_tab[s1] ^ {16{c1}};
  assign fc       = sig_tab[s2] ^ {16{c2}};
  assign gate_val = (fa & fb) | (fa & fc) | (fb & fc);

  // gate k may only use signals 0..4+k
  assign gate_fwd  = (int'(s0) >= 5 + int'(k)) || (int'(s1) >= 5 + int'(k)) ||
                     (int'(s2) >= 5 + int'(k));
  assign has_gates = (n_gates != '0);
  assign last_step = !has_gates || (k == n_gates - CNT_W'(1));
  assign out_bad   = int'(out_sel) >= 5 + int'(n_gates);

  // the final gate is still being computed in the last EVAL cycle, so bypass it
  assign out_src   = (has_gates && int'(out_sel) == 4 + int'(n_gates)) ?
                     gate_val : sig_tab[out_sel];
  assign err_final = err | (has_gates & gate_fwd) | out_bad;
  assign tt_final  = err_final ? 16'h0000 : (out_src ^ {16{out_cpl}});

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LOAD;
      n_gates     <= '0;
      k           <= '0;
      err         <= 1'b0;
      out_sel     <= '0;
      out_cpl     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_tt_q    <= 16'h0000;
      out_err_q   <= 1'b0;
`ifdef MIG_EVAL_ONESCNT_EN
      bus.out_ones <= 5'd0;
`endif
    end else begin
      case (state)
        LOAD: begin
          if (bus.in_valid) begin
            if (bus.in_last) begin
              out_sel    <= bus.in_gate[SEL_W-1:0];
              out_cpl    <= bus.in_gate[SEL_W];
              k          <= '0;
              in_ready_q <= 1'b0;
              state      <= EVAL;
            end else if (n_gates == CNT_W'(MAX_GATES)) begin
              err <= 1'b1;
            end else begin
              n_gates <= n_gates + CNT_W'(1);
            end
          end
        end
        EVAL: begin
          if (has_gates && gate_fwd) err <= 1'b1;
          if (last_step) begin
            out_tt_q    <= tt_final;
            out_err_q   <= err_final;
`ifdef MIG_EVAL_ONESCNT_EN
            bus.out_ones <= 5'($countones(tt_final));
`endif
            out_valid_q <= 1'b1;
            state       <= OUT;
          end else begin
            k <= k + CNT_W'(1);
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            n_gates     <= '0;
            err         <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= LOAD;
          end
        end
        default: begin
          state       <= LOAD;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // descriptor and gate storage carry no reset: N and k gate every read
  always_ff @(posedge clk) begin
    if (state == LOAD && bus.in_valid && !bus.in_last &&
        n_gates != CNT_W'(MAX_GATES))
      desc[n_gates[IDX_W-1:0]] <= bus.in_gate;
    if (state == EVAL && has_gates)
      gate_tt[k[IDX_W-1:0]] <= gate_val;
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_tt    = out_tt_q;
  assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_mig_netlist_eval.sv
// tb_mig_netlist_eval
//   Directed vectors for mig_netlist_eval. Stimulus pushes the expected
//   result into a queue before the last beat; a monitor pops and compares
//   each time out_valid rises.
module tb_mig_netlist_eval;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mig_netlist_eval_if #(.SEL_W(4)) bus ();

  mig_netlist_eval #(.MAX_GATES(8), .SEL_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] tt;
    logic        err;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   beat_cyc = 0;
  logic prev_valid = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endfunction

  function automatic logic [14:0] mk(logic c2, logic [3:0] s2, logic c1, logic [3:0] s1,
                                     logic c0, logic [3:0] s0);
    return {c2, s2, c1, s1, c0, s0};
  endfunction

  // monitor
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (bus.out_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_output: got out_valid=1 out_tt=%h, expected no result", bus.out_tt);
      end else begin
        e = exp_q.pop_front();
        check("out_tt", 32'(bus.out_tt), 32'(e.tt));
        check("out_err", 32'(bus.out_err), 32'(e.err));
        if (e.lat >= 0) check("latency", 32'(cyc - beat_cyc), 32'(e.lat));
`ifdef MIG_EVAL_ONESCNT_EN
        check("out_ones", 32'(bus.out_ones), 32'($countones(e.tt)));
`endif
      end
    end
    prev_valid = bus.out_valid;
  end

  task automatic expect_res(input logic [15:0] tt, input logic err, input int lat);
    exp_t e;
    e.tt = tt; e.err = err; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic last, input logic [14:0] g);
    int guard = 0;
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    bus.in_gate  = g;
    while (!bus.in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!bus.in_ready) begin
      n_checks++;
      $display("FAIL in_ready_timeout: got in_ready=0, expected 1 within 100 cycles");
    end
    beat_cyc = cyc;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_done();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL result_timeout: got %0d pending results, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic send_four();
    send(1'b0, mk(0, 4'd0, 0, 4'd2, 0, 4'd1));   // g0 = x0&x1       = 8888
    send(1'b0, mk(1, 4'd0, 0, 4'd4, 0, 4'd3));   // g1 = x2|x3       = FFF0
    send(1'b0, mk(0, 4'd0, 0, 4'd6, 0, 4'd5));   // g2 = g0&g1       = 8880
    send(1'b0, mk(0, 4'd0, 0, 4'd1, 1, 4'd7));   // g3 = ~g2&x0      = 222A
  endtask

  initial begin
    int guard;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_gate   = '0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_tt", 32'(bus.out_tt), 32'd0);
    check("rst_out_err", 32'(bus.out_err), 32'd0);

    // MAJ(x0,x1,x2)
    expect_res(16'hE8E8, 1'b0, -1);
    send(1'b0, mk(0, 4'd3, 0, 4'd2, 0, 4'd1));
    send(1'b1, mk(0, 4'd0, 0, 4'd0, 0, 4'd5));
    wait_done();

    // AND and OR
    expect_res(16'h8888, 1'b0, -1);
    send(1'b0, mk(0, 4'd0, 0, 4'd2, 0, 4'd1));
    send(1'b1, mk(0, 4'd0, 0, 4'd0, 0, 4'd5));
    wait_done();
    expect_res(16'hEEEE, 1'b0, -1);
    send(1'b0, mk(1, 4'd0, 0, 4'd2, 0, 4'd1));
    send(1'b1, mk(0, 4'd0, 0, 4'd0, 0, 4'd5));
    wait_done();

    // zero gates, complemented x3
    expect_res(16'h00FF, 1'b0, 2);
    send(1'b1, mk(0, 4'd0, 0, 4'd0, 1, 4'd4));
    wait_done();

    // self reference
    expect_res(16'h0000, 1'b1, -1);
    send(1'b0, mk(0, 4'd3, 0, 4'd2, 0, 4'd5));
    send(1'b1, mk(0, 4'd0, 0, 4'd0, 0, 4'd5));
    wait_done();

    // overflow: MAX_GATES+1 non-last beats
    expect_res(16'h0000, 1'b1, -1);
    for (int i = 0; i < 9; i++) send(1'b0, mk(0, 4'd3, 0, 4'd2, 0, 4'd1));
    send(1'b1, mk(0, 4'd0, 0, 4'd0, 0, 4'd5));
    wait_done();

    // output selector beyond the netlist
    expect_res(16'h0000, 1'b1, -1);
    send(1'b0, mk(0, 4'd3, 0, 4'd2, 0, 4'd1));
    send(1'b0, mk(0, 4'd3, 0, 4'd2, 0, 4'd5));
    send(1'b1, mk(0, 4'd0, 0, 4'd0, 0, 4'd9));
    wait_done();

    // backpressure: g0 = x0&x1, g1 = g0|x2 = F8F8
    bus.out_ready = 1'b0;
    expect_res(16'hF8F8, 1'b0, 3);
    send(1'b0, mk(0, 4'd0, 0, 4'd2, 0, 4'd1));
    send(1'b0, mk(1, 4'd0, 0, 4'd3, 0, 4'd5));
    send(1'b1, mk(0, 4'd0, 0, 4'd0, 0, 4'd6));
    guard = 0;
    while (!bus.out_valid && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_out_tt", 32'(bus.out_tt), 32'hF8F8);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_out_valid", 32'(bus.out_valid), 32'd0);
    check("release_in_ready", 32'(bus.in_ready), 32'd1);
    wait_done();

    // reset in the middle of EVAL: no result may appear
    send_four();
    send(1'b1, mk(0, 4'd0, 0, 4'd0, 1, 4'd8));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_eval_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_eval_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (8) @(posedge clk);
    #1;

    // fresh 4-gate netlist, output ~g3
    expect_res(16'hDDD5, 1'b0, 5);
    send_four();
    send(1'b1, mk(0, 4'd0, 0, 4'd0, 1, 4'd8));
    wait_done();

    // same netlist, output an earlier gate complemented: ~g1
    expect_res(16'h000F, 1'b0, 5);
    send_four();
    send(1'b1, mk(0, 4'd0, 0, 4'd0, 1, 4'd6));
    wait_done();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
